pipe_reg_elastic: RTL and testbench
===================================

// Module: pipe_reg_elastic
// PURPOSE
//  Parametrised multi-stage pipeline register with valid/ready handshake, global enable,
//  synchronous flush and optional bubble collapsing. Successor to the single-bit enable
//  flip-flop used between processor pipeline stages. Carries WIDTH-bit words through
//  DEPTH register stages and reports occupancy.
// PARAMETERS
//  WIDTH     8   data width in bits (>=1)
//  DEPTH     2   number of register stages (>=1)
//  COLLAPSE  1   1: stages advance independently (bubbles squeezed out); 0: lock-step shift
//  RESET_VAL 0   value loaded into every data register on reset
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               asynchronous, active-high reset
//  en         in   1               global enable; low = freeze all state
//  flush      in   1               synchronous clear of all valid bits
//  in_valid   in   1               upstream word present on d
//  in_ready   out  1               block accepts d this cycle
//  d          in   WIDTH           input word
//  out_valid  out  1               q holds a valid word
//  out_ready  in   1               downstream accepts q this cycle
//  q          out  WIDTH           output word (last stage register)
//  count      out  $clog2(DEPTH+1) number of valid stages
// BEHAVIOUR
//  - State: per stage s (0 = input side, DEPTH-1 = output side): data[s], v[s].
//  - Reset (async, highest priority): v[] = 0, data[] = RESET_VAL, count = 0. Output values are
//    out_valid = 0, q = RESET_VAL, count = 0. in_ready = 0 while reset is asserted.
//  - Priority each edge: reset > flush > en.
//  - flush = 1 (with en either value): v[] = 0, count = 0 at the next edge. data[] holds.
//    in_ready = 0 during flush, so d is not captured even if in_valid = 1.
//  - en = 0 and no flush: no register changes. in_ready = 0. out_valid/q still show the held
//    state. Downstream must not treat out_valid & out_ready as a transfer while en = 0.
//  - Transfer events: accept = in_valid & in_ready; emit = out_valid & out_ready & en & ~flush.
//  - COLLAPSE = 1:
//    - adv[DEPTH-1] = emit.
//    - For s < DEPTH-1, stage s+1 can take = ~v[s+1] | adv[s+1]; adv[s] = en & ~flush & v[s] & (s+1 can take).
//    - in_ready = en & ~flush & (~v[0] | adv[0]).
//    - A moving stage loads data[s+1] <= data[s], v[s+1] <= 1.
//    - A stage that gives up its word and receives nothing clears its v.
//  - COLLAPSE = 0:
//    - step = en & ~flush & (~v[DEPTH-1] | out_ready).
//    - On step, all stages shift together: v[0] <= accept, data[0] <= d.
//    - in_ready = step.
//  - Data registers load only when their stage receives a valid word. An empty stage is not
//    overwritten.
//  - Latency: a word accepted at edge N appears on q with out_valid after edge N+DEPTH-1 when
//    there is no stall. For DEPTH = 1, it is visible right after the accept edge.
//    Throughput is 1 word per cycle.
//  - Full with out_ready = 1: in_ready = 1 (simultaneous accept and emit). count is unchanged.
//  - count is a registered up/down counter: +1 on accept only, -1 on emit only, unchanged on
//    both or neither, 0 on flush. It must always equal popcount(v[]).
//  - out_valid and q are driven directly from registers. in_ready may depend combinationally
//    on out_ready.
// TESTING
//  1 WIDTH=8, DEPTH=3, stream 0x11,0x22,0x33,0x44 with out_ready=1:
//    q=0x11 with out_valid=1 two edges after its accept, then one word per cycle; count peaks at 3.
//  2 out_ready=0, push 4 words: after 3 accepts count=3, in_ready=0, 4th word is held off.
//    Raise out_ready: 0x11 emitted and 4th word accepted on the same edge; count stays 3.
//  3 COLLAPSE=1 vs 0, DEPTH=3: load one word, stall out_ready=0, then push a second word.
//    COLLAPSE=1 packs both words (count=2, v=3'b110); COLLAPSE=0 leaves the bubble and
//    in_ready=0.
//  4 Full pipeline with flush=1 and in_valid=1 on the same cycle: next cycle count=0,
//    out_valid=0, d is not captured; the next accept then proceeds normally.
//  5 en=0 for 5 cycles mid-stream with in_valid=out_ready=1: q, count and v are frozen and
//    in_ready=0. Streaming resumes unchanged when en returns to 1.
//  6 Assert reset asynchronously between clock edges while the pipeline holds 2 words:
//    out_valid=0, count=0, q=RESET_VAL immediately, with no clock edge needed.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// Multi-stage elastic pipeline register with valid/ready handshake, global enable,
// synchronous flush and optional bubble collapsing; reports the number of occupied stages.
module pipe_reg_elastic #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter int               COLLAPSE  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] adv;
  logic [CW-1:0]    count_q, count_d;
  logic             run, step, emit, ready_int, accept;

  always_comb begin
    logic take_next;
    run       = en & ~flush;
    step      = run & (~v_q[DEPTH-1] | out_ready);
    emit      = v_q[DEPTH-1] & out_ready & run;
    adv       = '0;
    ready_int = 1'b0;
    take_next = 1'b0;
    if (COLLAPSE != 0) begin
      // Each stage moves when the one ahead is empty or emptying in the same edge.
      adv[DEPTH-1] = emit;
      take_next    = emit;
      for (int s = DEPTH - 2; s >= 0; s--) begin
        take_next = run & v_q[s] & (~v_q[s+1] | take_next);
        adv[s]    = take_next;
      end
      ready_int = run & (~v_q[0] | adv[0]);
    end else begin
      adv       = {DEPTH{step}} & v_q;
      ready_int = step;
    end
    accept = in_valid & ready_int;

    v_d    = v_q;
    data_d = data_q;
    if (flush) begin
      v_d = '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        if (adv[s]) v_d[s] = 1'b0;
      end
      if (accept) begin
        v_d[0]    = 1'b1;
        data_d[0] = d;
      end
      for (int s = 1; s < DEPTH; s++) begin
        if (adv[s-1]) begin
          v_d[s]    = 1'b1;
          data_d[s] = data_q[s-1];
        end
      end
    end

    if (flush) count_d = '0;
    else       count_d = count_q + CW'(accept) - CW'(emit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int s = 0; s < DEPTH; s++) data_q[s] <= RESET_VAL;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  // Reset only gates the visible ready; the flops are held in reset regardless.
  assign in_ready  = ready_int & ~reset;
  assign out_valid = v_q[DEPTH-1];
  assign q         = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: COLLAPSE=1 and COLLAPSE=0 instances (DEPTH=3) driven in parallel,
// each checked every cycle against a word-list model, plus directed literal checks.
module tb_pipe_reg_elastic;
  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0, reset = 1'b0, en = 1'b0, flush = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] d = '0;
  logic       ir1, ov1, ir0, ov0;
  logic [7:0] q1, q0;
  logic [1:0] c1, c0;

  pipe_reg_elastic #(.WIDTH(W), .DEPTH(D), .COLLAPSE(1), .RESET_VAL(RV)) u1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .d(d), .out_valid(ov1), .out_ready(out_ready), .q(q1), .count(c1));

  pipe_reg_elastic #(.WIDTH(W), .DEPTH(D), .COLLAPSE(0), .RESET_VAL(RV)) u0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .d(d), .out_valid(ov0), .out_ready(out_ready), .q(q0), .count(c0));

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // Model: per instance, a list of words oldest first, each with its stage position.
  int         n     [2];
  int         mpos  [2][3];
  logic [7:0] mdat  [2][3];
  logic [7:0] lastq [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ov(int c);
    return n[c] > 0 && mpos[c][0] == D - 1;
  endfunction

  function automatic logic [2:0] model_v(int c);
    logic [2:0] v;
    v = '0;
    for (int k = 0; k < n[c]; k++) v[mpos[c][k]] = 1'b1;
    return v;
  endfunction

  function automatic bit exp_ready(int c);
    int tp[3];
    int tn;
    int st;
    if (reset || !en || flush) return 1'b0;
    if (c == 0) return (n[c] == 0 || mpos[c][0] != D - 1 || out_ready);
    st = (exp_ov(c) && out_ready) ? 1 : 0;
    tn = 0;
    for (int k = st; k < n[c]; k++) begin
      tp[tn] = mpos[c][k];
      if (tp[tn] < D - 1) begin
        if (tn == 0) tp[tn]++;
        else if (tp[tn-1] > tp[tn] + 1) tp[tn]++;
      end
      tn++;
    end
    if (tn == 0) return 1'b1;
    return tp[tn-1] != 0;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      n[c]     = 0;
      lastq[c] = RV;
    end
  endtask

  task automatic model_edge(int c);
    bit ir, acc, emt;
    if (flush) begin
      n[c] = 0;
      return;
    end
    if (!en) return;
    ir  = exp_ready(c);
    acc = in_valid && ir;
    emt = exp_ov(c) && out_ready;
    if (emt) begin
      for (int k = 1; k < n[c]; k++) begin
        mpos[c][k-1] = mpos[c][k];
        mdat[c][k-1] = mdat[c][k];
      end
      n[c]--;
    end
    for (int k = 0; k < n[c]; k++) begin
      if (c == 1) begin
        if (mpos[c][k] < D - 1) begin
          if (k == 0) mpos[c][k]++;
          else if (mpos[c][k-1] > mpos[c][k] + 1) mpos[c][k]++;
        end
      end else if (ir) begin
        mpos[c][k]++;
      end
    end
    if (acc) begin
      mpos[c][n[c]] = 0;
      mdat[c][n[c]] = d;
      n[c]++;
    end
    if (exp_ov(c)) lastq[c] = mdat[c][0];
  endtask

  initial model_clear();

  always @(posedge clk) begin
    if (!reset) begin
      model_edge(0);
      model_edge(1);
    end
  end

  always @(negedge clk) begin
    if (reset) model_clear();
    chk("c1.out_valid", ov1, exp_ov(1));
    chk("c1.q",         q1,  lastq[1]);
    chk("c1.count",     c1,  n[1]);
    chk("c1.in_ready",  ir1, exp_ready(1));
    chk("c0.out_valid", ov0, exp_ov(0));
    chk("c0.q",         q0,  lastq[0]);
    chk("c0.count",     c0,  n[0]);
    chk("c0.in_ready",  ir0, exp_ready(0));
  end

  task automatic drive(input bit e, input bit f, input bit iv, input logic [7:0] dd, input bit ordy);
    en = e; flush = f; in_valid = iv; d = dd; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset q1", q1, RV);
    chk("reset count1", c1, 0);
    chk("reset ov0", ov0, 0);
    chk("reset in_ready1", ir1, 0);
    reset = 1'b0;

    // Streaming with out_ready high
    drive(1, 0, 1, 8'h11, 1); tick();
    chk("t1 count after first accept", c1, 1);
    chk("t1 out_valid after first accept", ov1, 0);
    drive(1, 0, 1, 8'h22, 1); tick();
    drive(1, 0, 1, 8'h33, 1); tick();
    chk("t1 ov1", ov1, 1); chk("t1 q1", q1, 8'h11); chk("t1 c1 peak", c1, 3);
    chk("t1 q0", q0, 8'h11); chk("t1 c0 peak", c0, 3);
    drive(1, 0, 1, 8'h44, 1); tick();
    chk("t1 q1 second", q1, 8'h22); chk("t1 c1 steady", c1, 3);
    drive(1, 0, 0, 8'h00, 1); tick();
    chk("t1 q1 third", q1, 8'h33); chk("t1 c1 draining", c1, 2);
    tick();
    chk("t1 q1 fourth", q1, 8'h44); chk("t1 c1 last", c1, 1);
    tick();
    chk("t1 ov1 empty", ov1, 0); chk("t1 c1 empty", c1, 0); chk("t1 q1 held", q1, 8'h44);

    // Backpressure then simultaneous accept and emit
    drive(1, 0, 1, 8'h11, 0); tick();
    drive(1, 0, 1, 8'h22, 0); tick();
    drive(1, 0, 1, 8'h33, 0); tick();
    chk("t2 c1 full", c1, 3); chk("t2 c0 full", c0, 3); chk("t2 q1", q1, 8'h11);
    drive(1, 0, 1, 8'h44, 0); #1;
    chk("t2 ir1 full stalled", ir1, 0); chk("t2 ir0 full stalled", ir0, 0);
    tick();
    chk("t2 c1 held off", c1, 3); chk("t2 q1 held", q1, 8'h11);
    drive(1, 0, 1, 8'h44, 1); #1;
    chk("t2 ir1 full draining", ir1, 1); chk("t2 ir0 full draining", ir0, 1);
    tick();
    chk("t2 q1 after swap", q1, 8'h22); chk("t2 c1 after swap", c1, 3);
    chk("t2 q0 after swap", q0, 8'h22); chk("t2 c0 after swap", c0, 3);
    drive(1, 0, 0, 8'h00, 1); repeat (3) tick();
    chk("t2 c1 drained", c1, 0); chk("t2 q1 last", q1, 8'h44);

    // Bubble collapsing versus lock-step
    drive(1, 0, 1, 8'h55, 0); tick();
    drive(1, 0, 0, 8'h00, 0); tick(); tick();
    chk("t3 ov1", ov1, 1); chk("t3 ov0", ov0, 1); chk("t3 q0", q0, 8'h55);
    drive(1, 0, 1, 8'h66, 0); #1;
    chk("t3 ir1 with bubble", ir1, 1); chk("t3 ir0 with bubble", ir0, 0);
    tick();
    chk("t3 c1 two words", c1, 2); chk("t3 c0 one word", c0, 1);
    drive(1, 0, 0, 8'h00, 0); tick();
    chk("t3 c1 packed", c1, 2); chk("t3 q1", q1, 8'h55);
    chk("t3 model v collapse", model_v(1), 3'b110);
    chk("t3 model v lockstep", model_v(0), 3'b100);
    drive(1, 0, 0, 8'h00, 1); repeat (3) tick();
    chk("t3 c1 drained", c1, 0); chk("t3 c0 drained", c0, 0);

    // Flush on a full pipeline with a word offered
    drive(1, 0, 1, 8'h71, 0); tick();
    drive(1, 0, 1, 8'h72, 0); tick();
    drive(1, 0, 1, 8'h73, 0); tick();
    chk("t4 c1 full", c1, 3);
    drive(1, 1, 1, 8'h77, 1); #1;
    chk("t4 ir1 flush", ir1, 0); chk("t4 ir0 flush", ir0, 0);
    tick();
    chk("t4 c1 flushed", c1, 0); chk("t4 ov1 flushed", ov1, 0);
    chk("t4 c0 flushed", c0, 0); chk("t4 ov0 flushed", ov0, 0);
    chk("t4 q1 data holds", q1, 8'h71);
    drive(1, 0, 1, 8'h88, 1); tick();
    chk("t4 c1 after flush accept", c1, 1);
    drive(1, 0, 0, 8'h00, 1); tick(); tick();
    chk("t4 ov1", ov1, 1); chk("t4 q1", q1, 8'h88); chk("t4 q0", q0, 8'h88);
    tick();
    chk("t4 c1 drained", c1, 0);

    // Global enable low mid-stream
    drive(1, 0, 1, 8'h01, 1); tick();
    drive(1, 0, 1, 8'h02, 1); tick();
    drive(1, 0, 1, 8'h03, 1); tick();
    chk("t5 q1 before freeze", q1, 8'h01); chk("t5 c1 before freeze", c1, 3);
    drive(0, 0, 1, 8'h04, 1); #1;
    chk("t5 ir1 frozen", ir1, 0); chk("t5 ir0 frozen", ir0, 0);
    repeat (5) begin
      tick();
      chk("t5 q1 frozen", q1, 8'h01); chk("t5 c1 frozen", c1, 3); chk("t5 ov1 frozen", ov1, 1);
      chk("t5 q0 frozen", q0, 8'h01); chk("t5 c0 frozen", c0, 3);
    end
    drive(1, 0, 1, 8'h04, 1); tick();
    chk("t5 q1 resumed", q1, 8'h02); chk("t5 c1 resumed", c1, 3); chk("t5 q0 resumed", q0, 8'h02);
    drive(1, 0, 0, 8'h00, 1); repeat (3) tick();
    chk("t5 c1 drained", c1, 0);

    // Asynchronous reset between edges
    drive(1, 0, 1, 8'hC1, 0); tick();
    drive(1, 0, 1, 8'hC2, 0); tick();
    chk("t6 c1 two words", c1, 2);
    drive(1, 0, 0, 8'h00, 0);
    #2 reset = 1'b1;
    #1;
    chk("t6 ov1 async", ov1, 0); chk("t6 c1 async", c1, 0); chk("t6 q1 async", q1, RV);
    chk("t6 ir1 async", ir1, 0); chk("t6 c0 async", c0, 0); chk("t6 q0 async", q0, RV);
    tick();
    reset = 1'b0;
    tick();
    chk("t6 c1 after release", c1, 0); chk("t6 q1 after release", q1, RV);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      en        = ($urandom % 8) != 0;
      flush     = ($urandom % 20) == 0;
      in_valid  = ($urandom % 4) != 0;
      d         = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      if (($urandom % 250) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
    end
    drive(1, 0, 0, 8'h00, 1);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
